// File: rtl/sdram_p2_queue.sv
// sdram_p2_queue: buffered word request queue for port 2 of the SDRAM
// controller. Requests are stored in a FIFO and issued one at a time on p2_*;
// each issued request is held stable until p2_ack toggles or the watchdog
// expires. Reads return data on a one-cycle o_rsp_valid strobe.
//
// Handshake: a request is accepted on a rising clk edge where
// i_req_valid & o_req_ready are both high; o_req_ready is registered and
// already accounts for that cycle's push/pop, so the requester never needs
// to look at anything else.
module sdram_p2_queue #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      i_ram_ready,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_we,
  input  logic [21:0]               i_req_addr,
  input  logic [15:0]               i_req_din,
  input  logic [1:0]                i_req_ds,
  output logic                      o_rsp_valid,
  output logic [15:0]               o_rsp_data,
  output logic                      o_p2_cs,
  output logic                      o_p2_we,
  output logic [21:0]               o_p2_addr,
  output logic [15:0]               o_p2_din,
  output logic [1:0]                o_p2_ds,
  input  logic                      i_p2_ack,
  input  logic [15:0]               i_p2_dout,
  output logic                      o_busy,
  output logic                      o_err_timeout,
  output logic [1:0]                o_dbg_state,
  output logic [$clog2(DEPTH):0]    o_dbg_count
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  // FIFO storage: entry = {we, addr[21:0], din[15:0], ds[1:0]}
  logic [40:0]    r_mem [DEPTH];
  logic [AW:0]    r_wr_ptr;
  logic [AW:0]    r_rd_ptr;
  logic           r_req_ready;

  logic [1:0]     r_state;
  logic [WDW-1:0] r_wd;
  logic           r_ack_seen;
  logic           r_p2_cs;
  logic           r_p2_we;
  logic [21:0]    r_p2_addr;
  logic [15:0]    r_p2_din;
  logic [1:0]     r_p2_ds;
  logic           r_rsp_valid;
  logic [15:0]    r_rsp_data;
  logic           r_busy;
  logic           r_err_timeout;

  logic [AW:0]    w_count;
  logic [AW:0]    w_count_nxt;
  logic [40:0]    w_head;
  logic           w_push;
  logic           w_pop;
  logic           w_issue;
  logic           w_ack_evt;
  logic           w_timeout_evt;
  logic [1:0]     w_state_nxt;

  assign w_push      = i_req_valid & r_req_ready;
  assign w_count     = r_wr_ptr - r_rd_ptr;
  assign w_count_nxt = w_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_head      = r_mem[r_rd_ptr[AW-1:0]];

  // FIFO storage write; contents need no reset since the pointers gate them
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {i_req_we, i_req_addr, i_req_din, i_req_ds};
    end
  end

  // FIFO pointers, registered ready and busy flags
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_req_ready <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_req_ready <= (w_count_nxt < (AW+1)'(DEPTH));
      r_busy      <= (w_count_nxt != '0) | (w_state_nxt != S_IDLE);
    end
  end

  // Next-state decode: issue from IDLE, complete on ack (priority) or watchdog
  always_comb begin
    w_state_nxt   = r_state;
    w_issue       = 1'b0;
    w_pop         = 1'b0;
    w_ack_evt     = 1'b0;
    w_timeout_evt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((w_count != '0) && i_ram_ready) begin
          w_issue     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_p2_ack != r_ack_seen) begin
          w_ack_evt   = 1'b1;
          w_pop       = 1'b1;
          w_state_nxt = S_GAP;
        end else if (r_wd == WDW'(TIMEOUT)) begin
          w_timeout_evt = 1'b1;
          w_pop         = 1'b1;
          w_state_nxt   = S_GAP;
        end
      end
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state, port-2 request registers, watchdog and read response
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_wd          <= '0;
      r_ack_seen    <= i_p2_ack;
      r_p2_cs       <= 1'b0;
      r_p2_we       <= 1'b0;
      r_p2_addr     <= '0;
      r_p2_din      <= '0;
      r_p2_ds       <= 2'b11;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      // Outside WAIT this resyncs stray toggles; inside WAIT a difference is
      // consumed as the completion of the current access in the same edge.
      r_ack_seen  <= i_p2_ack;
      r_rsp_valid <= 1'b0;
      if (r_state == S_WAIT) r_wd <= r_wd + 1'b1;
      if (w_issue) begin
        {r_p2_we, r_p2_addr, r_p2_din, r_p2_ds} <= w_head;
        r_p2_cs <= 1'b1;
        r_wd    <= '0;
      end
      if (w_ack_evt) begin
        r_p2_cs <= 1'b0;
        if (!r_p2_we) begin
          r_rsp_data  <= i_p2_dout;
          r_rsp_valid <= 1'b1;
        end
      end
      if (w_timeout_evt) begin
        r_p2_cs       <= 1'b0;
        r_err_timeout <= 1'b1;
        if (!r_p2_we) begin
          r_rsp_data  <= 16'hFFFF;
          r_rsp_valid <= 1'b1;
        end
      end
    end
  end

  assign o_req_ready   = r_req_ready;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_data    = r_rsp_data;
  assign o_p2_cs       = r_p2_cs;
  assign o_p2_we       = r_p2_we;
  assign o_p2_addr     = r_p2_addr;
  assign o_p2_din      = r_p2_din;
  assign o_p2_ds       = r_p2_ds;
  assign o_busy        = r_busy;
  assign o_err_timeout = r_err_timeout;
  assign o_dbg_state   = r_state;
  assign o_dbg_count   = w_count;

endmodule

// File: tb/tb_sdram_p2_queue.sv
// Bench for sdram_p2_queue: a controller model serves port 2 with a
// programmable ack delay; issued accesses and read responses are checked
// against expected queues filled as requests are driven.
module tb_sdram_p2_queue;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 255;

  logic        clk;
  logic        reset_n;
  logic        ram_ready;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [21:0] req_addr;
  logic [15:0] req_din;
  logic [1:0]  req_ds;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        p2_cs;
  logic        p2_we;
  logic [21:0] p2_addr;
  logic [15:0] p2_din;
  logic [1:0]  p2_ds;
  logic        p2_ack;
  logic [15:0] p2_dout;
  logic        busy;
  logic        err_timeout;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_count;

  sdram_p2_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .i_ram_ready(ram_ready),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_din(req_din), .i_req_ds(req_ds),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .o_p2_cs(p2_cs), .o_p2_we(p2_we), .o_p2_addr(p2_addr),
    .o_p2_din(p2_din), .o_p2_ds(p2_ds), .i_p2_ack(p2_ack),
    .i_p2_dout(p2_dout), .o_busy(busy), .o_err_timeout(err_timeout),
    .o_dbg_state(dbg_state), .o_dbg_count(dbg_count)
  );

  // Scoreboard queues and counters
  logic [40:0] exp_q[$];
  logic [15:0] rsp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_done   = 0;
  int n_rsp    = 0;

  // Controller model knobs and state
  logic        ack_en    = 1'b1;
  int          ack_delay = 5;
  logic        use_fixed = 1'b0;
  logic [15:0] fixed_dout = 16'h0;
  logic        m_active = 1'b0;
  logic        m_acked  = 1'b0;
  logic        m_unstable = 1'b0;
  logic [40:0] m_cap;
  int          m_k = 0;
  int          m_last_len = 0;

  // Clock and global time limit
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, passed=%0d total=%0d", n_pass, n_checks);
    $fatal(1, "time limit");
  end

  // Controller model: check each issued access, hold-stability, then ack
  initial begin
    forever begin
      @(negedge clk);
      if (p2_cs) begin
        if (!m_active) begin
          m_active = 1'b1; m_k = 0; m_acked = 1'b0; m_unstable = 1'b0;
          m_cap = {p2_we, p2_addr, p2_din, p2_ds};
          n_checks++;
          if (exp_q.size() == 0) begin
            $display("FAIL issue_order: unexpected access got=%h required=none", m_cap);
          end else begin
            logic [40:0] e;
            e = exp_q.pop_front();
            if (m_cap !== e) $display("FAIL issue_order: got=%h required=%h", m_cap, e);
            else n_pass++;
          end
        end else if ({p2_we, p2_addr, p2_din, p2_ds} !== m_cap) begin
          m_unstable = 1'b1;
        end
        m_k++;
        if (ack_en && !m_acked && m_k >= ack_delay) begin
          p2_dout = use_fixed ? fixed_dout : 16'($urandom);
          p2_ack  = ~p2_ack;
          m_acked = 1'b1;
          if (!m_cap[40]) rsp_q.push_back(p2_dout);
        end
      end else if (m_active) begin
        m_active = 1'b0;
        m_last_len = m_k;
        n_done++;
        n_checks++;
        if (m_unstable) $display("FAIL hold_stable: fields changed while p2_cs high got=1 required=0");
        else n_pass++;
      end
    end
  end

  // Response monitor: every rsp_valid must match the next expected read data
  initial begin
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        n_rsp++;
        n_checks++;
        if (rsp_q.size() == 0) begin
          $display("FAIL rsp_data: unexpected rsp_valid got=%h required=none", rsp_data);
        end else begin
          logic [15:0] e;
          e = rsp_q.pop_front();
          if (rsp_data !== e) $display("FAIL rsp_data: got=%h required=%h", rsp_data, e);
          else n_pass++;
        end
      end
    end
  end

  // Driver: offer one request for one cycle; called at posedge+1
  task automatic push_req(input logic we, input logic [21:0] addr,
                          input logic [15:0] din, input logic [1:0] ds);
    int n = 0;
    while (!req_ready && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (!req_ready) begin
      n_checks++;
      $display("FAIL push_wait: req_ready got=0 required=1 within 400 cycles");
    end else begin
      req_valid = 1'b1; req_we = we; req_addr = addr; req_din = din; req_ds = ds;
      exp_q.push_back({we, addr, din, ds});
      @(posedge clk); #1;
      req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || m_active) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (busy) $display("FAIL wait_idle: busy got=1 required=0 after %0d cycles", budget);
    else n_pass++;
  endtask

  task automatic wait_cs(input int budget);
    int n = 0;
    while (!p2_cs && n < budget) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (!p2_cs) $display("FAIL wait_cs: p2_cs got=0 required=1 within %0d cycles", budget);
    else n_pass++;
  endtask

  task automatic check_reset_values(input string tag);
    n_checks++;
    if ({p2_cs, p2_we, p2_addr, p2_din, p2_ds} !== {1'b0, 1'b0, 22'h0, 16'h0, 2'b11})
      $display("FAIL %s_p2: got=%h required=%h", tag, {p2_cs, p2_we, p2_addr, p2_din, p2_ds}, {1'b0, 1'b0, 22'h0, 16'h0, 2'b11});
    else n_pass++;
    n_checks++;
    if ({rsp_valid, rsp_data, busy, err_timeout, req_ready} !== {1'b0, 16'h0, 1'b0, 1'b0, 1'b0})
      $display("FAIL %s_status: got=%h required=0", tag, {rsp_valid, rsp_data, busy, err_timeout, req_ready});
    else n_pass++;
    n_checks++;
    if ({dbg_state, dbg_count} !== 6'd0)
      $display("FAIL %s_fsm: got=%h required=0", tag, {dbg_state, dbg_count});
    else n_pass++;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ram_ready = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_din = '0; req_ds = 2'b11; p2_ack = 1'b0; p2_dout = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got=%b required=1", req_ready);
    else n_pass++;
  endtask

  task automatic test_single_write();
    int done0 = n_done;
    ack_delay = 9;
    push_req(1'b1, 22'h012345, 16'hBEEF, 2'b00);
    wait_idle(100);
    n_checks++;
    if (m_last_len != 9) $display("FAIL write_cs_len: got=%0d required=9", m_last_len);
    else n_pass++;
    n_checks++;
    if (n_done != done0 + 1 || rsp_q.size() != 0)
      $display("FAIL write_done: accesses got=%0d required=%0d", n_done - done0, 1);
    else n_pass++;
  endtask

  task automatic test_single_read();
    int rsp0 = n_rsp;
    use_fixed = 1'b1; fixed_dout = 16'hA55A; ack_delay = 6;
    push_req(1'b0, 22'h000100, 16'h0000, 2'b00);
    wait_idle(100);
    @(posedge clk); #1;
    n_checks++;
    if (n_rsp != rsp0 + 1) $display("FAIL read_rsp_count: got=%0d required=1", n_rsp - rsp0);
    else n_pass++;
    use_fixed = 1'b0;
  endtask

  task automatic test_fill();
    int done0 = n_done;
    ram_ready = 1'b0; ack_delay = 4;
    for (int i = 0; i < DEPTH; i++)
      push_req(1'b1, 22'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
    n_checks++;
    if (req_ready !== 1'b0 || dbg_count !== 4'd8)
      $display("FAIL fill_full: ready/count got=%b/%0d required=0/8", req_ready, dbg_count);
    else n_pass++;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 22'h3FFFFF; req_din = 16'hDEAD;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (dbg_count !== 4'd8 || p2_cs !== 1'b0)
      $display("FAIL fill_ignore: count/cs got=%0d/%b required=8/0", dbg_count, p2_cs);
    else n_pass++;
    ram_ready = 1'b1;
    wait_idle(300);
    n_checks++;
    if (n_done != done0 + DEPTH || exp_q.size() != 0 || dbg_count !== 4'd0)
      $display("FAIL fill_drain: accesses got=%0d required=%0d", n_done - done0, DEPTH);
    else n_pass++;
  endtask

  task automatic test_push_pop();
    int done0 = n_done;
    ram_ready = 1'b0; ack_delay = 3;
    for (int i = 0; i < 4; i++)
      push_req(1'b1, 22'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
    n_checks++;
    if (dbg_count !== 4'd4) $display("FAIL pp_pre_count: got=%0d required=4", dbg_count);
    else n_pass++;
    ram_ready = 1'b1;
    wait_cs(20);
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 22'h2AAAAA; req_din = 16'h5555; req_ds = 2'b01;
    exp_q.push_back({1'b1, 22'h2AAAAA, 16'h5555, 2'b01});
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_checks++;
    if (dbg_count !== 4'd4 || p2_cs !== 1'b0)
      $display("FAIL pp_same_cycle: count/cs got=%0d/%b required=4/0", dbg_count, p2_cs);
    else n_pass++;
    wait_idle(200);
    n_checks++;
    if (n_done != done0 + 5 || exp_q.size() != 0)
      $display("FAIL pp_drain: accesses got=%0d required=5", n_done - done0);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int rsp0 = n_rsp;
    int n = 0;
    ack_en = 1'b0;
    push_req(1'b0, 22'h0ABCDE, 16'h0, 2'b00);
    rsp_q.push_back(16'hFFFF);
    while (n_rsp == rsp0 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    n_checks++;
    if (n_rsp != rsp0 + 1) $display("FAIL to_rsp: rsp count got=%0d required=1", n_rsp - rsp0);
    else n_pass++;
    wait_idle(20);
    n_checks++;
    if (err_timeout !== 1'b1) $display("FAIL to_err: got=%b required=1", err_timeout);
    else n_pass++;
    n_checks++;
    if (m_last_len < TIMEOUT || m_last_len > TIMEOUT + 1)
      $display("FAIL to_len: got=%0d required=%0d..%0d", m_last_len, TIMEOUT, TIMEOUT + 1);
    else n_pass++;
    ack_en = 1'b1; ack_delay = 5;
    push_req(1'b1, 22'h000042, 16'h1234, 2'b10);
    wait_idle(100);
    n_checks++;
    if (err_timeout !== 1'b1 || m_last_len != 5)
      $display("FAIL to_next: err/len got=%b/%0d required=1/5", err_timeout, m_last_len);
    else n_pass++;
  endtask

  task automatic test_stray_and_reset();
    int rsp0;
    p2_ack = ~p2_ack;
    @(posedge clk); #1;
    ack_delay = 5;
    push_req(1'b1, 22'h111111, 16'h2222, 2'b00);
    wait_idle(100);
    n_checks++;
    if (m_last_len != 5) $display("FAIL stray_ack: cs len got=%0d required=5", m_last_len);
    else n_pass++;
    if (p2_ack == 1'b0) begin
      p2_ack = 1'b1;
      @(posedge clk); #1;
    end
    ack_en = 1'b0;
    for (int i = 0; i < 3; i++)
      push_req(1'b1, 22'($urandom), 16'($urandom), 2'b00);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset_values("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    rsp0 = n_rsp;
    ack_en = 1'b1; ack_delay = 7; use_fixed = 1'b1; fixed_dout = 16'h1357;
    push_req(1'b0, 22'h0F0F0F, 16'h0, 2'b00);
    wait_idle(100);
    @(posedge clk); #1;
    n_checks++;
    if (m_last_len != 7 || n_rsp != rsp0 + 1 || p2_ack !== 1'b0)
      $display("FAIL post_reset_ack: len/rsp got=%0d/%0d required=7/1", m_last_len, n_rsp - rsp0);
    else n_pass++;
    use_fixed = 1'b0;
  endtask

  task automatic test_back_to_back();
    int done0 = n_done;
    ack_delay = $urandom_range(1, 6);
    for (int i = 0; i < 12; i++)
      push_req(1'($urandom_range(0, 1)), 22'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
    wait_idle(2000);
    @(posedge clk); #1;
    n_checks++;
    if (n_done != done0 + 12 || exp_q.size() != 0 || rsp_q.size() != 0)
      $display("FAIL b2b_drain: accesses got=%0d required=12 rsp_left=%0d", n_done - done0, rsp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_fill();
    test_push_pop();
    test_timeout();
    test_stray_and_reset();
    test_back_to_back();
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0 || rsp_q.size() != 0)
      $display("FAIL final_queues: left got=%0d/%0d required=0/0", exp_q.size(), rsp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
